uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter. It is the next generation of the fixed 8N1 sender, with configurable data width, parity mode and stop-bit count, and a valid/ready byte handshake that replaces rising-edge enable capture. It sits between a frame/packet sequencer and the board TXD pin, sharing sys_clk with the rest of the mainboard logic.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 9600, baud rate. BPS_CNT = CLK_FREQ/UART_BPS clock cycles per bit (integer division).
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame: 1 or 2.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- tx_valid  input  1  tx_data holds a word to send.
- tx_data  input  DATA_BITS  word to send; sampled only on the accept cycle.
- tx_ready  output  1  block can accept a word this cycle.
- tx_done  output  1  one-cycle pulse when a frame completes.
- uart_tx_busy  output  1  high while a frame is in progress.
- uart_txd  output  1  serial line, registered, idles high.

Behaviour:
- Reset values, applied asynchronously while sys_rst is high:
  - state IDLE; uart_txd 1; tx_done 0; uart_tx_busy 0; tx_ready 1 once reset releases.
  - Internal counters and the shift register are cleared.
- States and transitions:
  - IDLE: on accept -> START.
  - START: 1 bit period -> DATA.
  - DATA: DATA_BITS bit periods -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: 1 bit period -> STOP.
  - STOP: STOP_BITS bit periods -> IDLE.
- Accept = tx_valid && tx_ready. tx_ready = (state == IDLE).
  - On accept, tx_data is latched into the shift register.
- Latency: uart_txd goes low on the first clock edge after the accept cycle.
- Bit timing: every bit, including each stop bit, lasts exactly BPS_CNT cycles.
  - The bit counter runs 0..BPS_CNT-1; its width is $clog2(BPS_CNT).
  - There is no early stop-bit termination.
- Parity bit:
  - even: XOR of the data bits.
  - odd: inverted XOR of the data bits.
- Frame length in cycles = BPS_CNT * (1 + DATA_BITS + (PARITY != 0) + STOP_BITS).
- tx_done pulses on the last cycle of the final stop bit. The next cycle is IDLE with tx_ready = 1.
- Back-to-back: if tx_valid is held, the next word is accepted in the first IDLE cycle. The next start bit follows the last stop bit with exactly 1 extra cycle of idle-high.
- uart_tx_busy = (state != IDLE).
- tx_valid while busy: ignored. The word is not latched and tx_data may change freely.
- Reset mid-frame: uart_txd returns high immediately (asynchronously) and the partial frame is abandoned. tx_done is not pulsed.

Optional Feature:
- Macro UART_TX_BREAK_EN.
- With the macro:
  - Adds input tx_break (1 bit).
  - tx_break high while in IDLE enters state BREAK: uart_txd held 0, tx_ready 0, uart_tx_busy 1.
  - On tx_break falling, the block drives uart_txd high for one full bit period (mark-after-break), then returns to IDLE.
  - tx_break asserted mid-frame is deferred until the frame finishes.
- Without the macro: the port and the BREAK state do not exist, and behaviour is exactly as above.

Decomposition:
- Package uart_pkg holds:
  - the tx state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - parity mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - a function bps_cnt(clk_freq, bps).
- Sub-module uart_baud_gen is natural:
  - Parameter BPS_CNT; input run.
  - Output bit_end, pulsing on count BPS_CNT-1; count clears when run is low.
  - The future uart_rx_param reuses it.

Test Plan:
1. CLK_FREQ=50000000, UART_BPS=115200 (BPS_CNT=434), 8N1, send 0x55 -> txd is 0 for 434 cycles, then 1,0,1,0,1,0,1,0, then stop 1. tx_done fires 4340 cycles after the first low cycle.
2. PARITY=2, send 0x07 -> parity bit 1. PARITY=1, send 0x07 -> parity bit 0. Frame length 4774 cycles.
3. STOP_BITS=2, DATA_BITS=7, send 0x7F -> line high for 868 cycles after bit 6. tx_done at cycle 434*10=4340.
4. tx_valid held with 0xA5 then 0x3C -> two contiguous frames with a 1-cycle gap, both bytes decoded correctly by a bench UART model.
5. Assert sys_rst at cycle 2000 of a frame -> uart_txd=1 the same cycle, no tx_done. A new accept after release sends a clean frame.
6. With UART_TX_BREAK_EN: hold tx_break for 5000 cycles in IDLE -> txd low for 5000 cycles, then high for 434 cycles with tx_ready 0, then tx_ready 1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the parametrised UART blocks.
//   tx_state_e  - transmitter state encoding
//   PAR_*       - parity mode constants (0 none, 1 odd, 2 even)
//   bps_cnt()   - clock cycles per bit for a given clock and baud rate
//   parity_bit()- parity of the low nbits of a data word
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int bps_cnt(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [8:0] data, input int nbits, input int mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) begin
        p = p ^ data[i];
      end
    end
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer shared by the UART transmitter and receiver.
//   clk_i     - clock
//   rst_i     - asynchronous active-high reset
//   run_i     - count while high; the count is held at zero while low
//   bit_end_o - high on the last cycle (count BPS_CNT-1) of each bit period
module uart_baud_gen #(
  parameter int BPS_CNT = 434
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic bit_end_o
);

  localparam int CW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BPS_CNT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wraps at the end of each bit, cleared whenever not running.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = run_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with valid/ready word input.
//   sys_clk, sys_rst  - clock, asynchronous active-high reset
//   tx_valid, tx_data - word offer; tx_data is latched on the accept cycle
//   tx_ready          - high in IDLE (accept = tx_valid && tx_ready)
//   tx_done           - pulse on the last cycle of the final stop bit
//   uart_tx_busy      - high while not IDLE
//   uart_txd          - registered serial line, idles high
// Optional: define UART_TX_BREAK_EN to add input tx_break, which holds the
// line low (BREAK) from IDLE and follows release with one bit of mark.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 uart_tx_busy,
  output logic                 uart_txd
);

  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 run_s;
  logic                 bit_end_s;
  logic                 accept_s;
`ifdef UART_TX_BREAK_EN
  logic                 mark_q, mark_d;
`endif

`ifdef UART_TX_BREAK_EN
  // The timer only runs during the mark-after-break, not while the line is held low.
  assign run_s    = (state_q != ST_IDLE) && !((state_q == ST_BREAK) && !mark_q);
  assign tx_ready = (state_q == ST_IDLE) && !tx_break;
`else
  assign run_s    = (state_q != ST_IDLE);
  assign tx_ready = (state_q == ST_IDLE);
`endif

  assign accept_s     = tx_valid && tx_ready;
  assign uart_tx_busy = (state_q != ST_IDLE);
  assign tx_done      = (state_q == ST_STOP) && bit_end_s && (bit_idx_q == LAST_STOP);
  assign uart_txd     = txd_q;

  uart_baud_gen #(.BPS_CNT(BPS_CNT)) u_baud (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .run_i     (run_s),
    .bit_end_o (bit_end_s)
  );

  // Next-state logic; bit_idx counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
`ifdef UART_TX_BREAK_EN
    mark_d    = mark_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          state_d = ST_BREAK;
          mark_d  = 1'b0;
        end else
`endif
        if (accept_s) begin
          state_d   = ST_START;
          bit_idx_d = 4'd0;
          shift_d   = tx_data;
          par_d     = parity_bit(9'(tx_data), DATA_BITS, PARITY);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d   = ST_DATA;
          bit_idx_d = 4'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = 4'd0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d   = ST_STOP;
          bit_idx_d = 4'd0;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          bit_idx_d = 4'd0;
          if (bit_idx_q == LAST_STOP) begin
            state_d = ST_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_BREAK: begin
`ifdef UART_TX_BREAK_EN
        if (!mark_q) begin
          if (!tx_break) begin
            mark_d = 1'b1;
          end else begin
            mark_d = 1'b0;
          end
        end else if (bit_end_s) begin
          state_d = ST_IDLE;
          mark_d  = 1'b0;
        end else begin
          state_d = ST_BREAK;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level is decoded from the next state so the register lines up with state_q.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      ST_IDLE:   txd_d = 1'b1;
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = par_d;
      ST_STOP:   txd_d = 1'b1;
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  txd_d = mark_d;
`else
      ST_BREAK:  txd_d = 1'b1;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  // State, datapath and line registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= 4'd0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
`ifdef UART_TX_BREAK_EN
      mark_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
`ifdef UART_TX_BREAK_EN
      mark_q    <= mark_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations run side by side, each
// checked every cycle against a frame-vector model of the serial line.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int NI = 4;
  localparam int DB_T  [NI] = '{8, 7, 5, 9};
  localparam int PAR_T [NI] = '{0, 2, 1, 1};
  localparam int SB_T  [NI] = '{1, 2, 1, 2};
  localparam int CLK_T [NI] = '{50000000, 1300000, 1000000, 1000000};
  localparam int BPS_T [NI] = '{115200, 100000, 125000, 200000};
  localparam int BRK_AT[NI] = '{24000, 20000, 20000, 20000};
  localparam int BRK_LN[NI] = '{5000, 50, 50, 50};
  localparam int RUN_CYCLES = 30000;

  logic [NI-1:0] fin = '0;

  // Whole frame as a bit vector, index 0 = start bit; unused positions stay 1.
  function automatic logic [12:0] frame_bits(input logic [8:0] d, input int db, input int par);
    logic [12:0] f;
    logic p;
    f = '1;
    f[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[1+i] = d[i];
      p = p ^ d[i];
    end
    if (par != 0) f[1+db] = (par == 1) ? ~p : p;
    return f;
  endfunction

  function automatic int frame_len(input int db, input int par, input int sb, input int bps);
    return bps * (1 + db + ((par != 0) ? 1 : 0) + sb);
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", name, inst, $time, act, exp);
    end
  endtask

  // Hand-computed values that pin the model itself.
  initial begin
    logic [12:0] f;
    check("len_8n1", -1, frame_len(8, 0, 1, 434), 32'd4340);
    check("len_8e1", -1, frame_len(8, 2, 1, 434), 32'd4774);
    check("len_7n2", -1, frame_len(7, 0, 2, 434), 32'd4340);
    f = frame_bits(9'h055, 8, 0);
    check("bits_55", -1, {22'd0, f[9:0]}, 32'h2AA);
    f = frame_bits(9'h007, 8, 2);
    check("par_even_07", -1, {31'd0, f[9]}, 32'd1);
    f = frame_bits(9'h007, 8, 1);
    check("par_odd_07", -1, {31'd0, f[9]}, 32'd0);
  end

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int DB  = DB_T[g];
    localparam int PAR = PAR_T[g];
    localparam int SB  = SB_T[g];
    localparam int BPS = CLK_T[g] / BPS_T[g];
    localparam int LEN = frame_len(DB, PAR, SB, BPS);
    localparam int RST_OFF = (g == 0) ? 2000 : LEN / 2;

    logic rst, valid, ready, done, busy, txd, brk;
    logic [DB-1:0] data;

    uart_tx_param #(
      .CLK_FREQ(CLK_T[g]), .UART_BPS(BPS_T[g]), .DATA_BITS(DB),
      .PARITY(PAR), .STOP_BITS(SB)
    ) dut (
      .sys_clk      (clk),
      .sys_rst      (rst),
`ifdef UART_TX_BREAK_EN
      .tx_break     (brk),
`endif
      .tx_valid     (valid),
      .tx_data      (data),
      .tx_ready     (ready),
      .tx_done      (done),
      .uart_tx_busy (busy),
      .uart_txd     (txd)
    );

    initial begin
      int mode;  // 0 idle, 1 frame, 2 break low, 3 mark after break
      int off;
      int nfr;
      bit rst_hit;
      logic [12:0] fr;
      logic [8:0] words [3];
      logic exp_txd, exp_busy, exp_ready, exp_done, prev_busy;
      int starts[$];
      int dones[$];
      words = '{9'h055, 9'h0A5, 9'h03C};
      rst = 1'b1; valid = 1'b0; data = '0; brk = 1'b0;
      mode = 0; off = 0; nfr = 0; rst_hit = 1'b0; fr = '1; prev_busy = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_txd", g, {31'd0, txd}, 32'd1);
      check("rst_busy", g, {31'd0, busy}, 32'd0);
      check("rst_done", g, {31'd0, done}, 32'd0);
      rst = 1'b0;
      for (int c = 0; c < RUN_CYCLES; c++) begin
        @(negedge clk);
        exp_txd = 1'b1; exp_busy = 1'b0; exp_ready = !brk; exp_done = 1'b0;
        if (mode == 1) begin
          exp_txd = fr[off / BPS]; exp_busy = 1'b1; exp_ready = 1'b0; exp_done = (off == LEN - 1);
        end else if (mode >= 2) begin
          exp_txd = (mode == 3); exp_busy = 1'b1; exp_ready = 1'b0;
        end
        check("txd", g, {31'd0, txd}, {31'd0, exp_txd});
        check("busy", g, {31'd0, busy}, {31'd0, exp_busy});
        check("ready", g, {31'd0, ready}, {31'd0, exp_ready});
        check("done", g, {31'd0, done}, {31'd0, exp_done});
        if (busy && !prev_busy) starts.push_back(c);
        if (done) dones.push_back(c);
        prev_busy = busy;

        // Asynchronous reset in the middle of the fourth frame.
        if (!rst_hit && mode == 1 && nfr >= 4 && off == RST_OFF) begin
          rst = 1'b1; valid = 1'b0;
          #1;
          check("rst_mid_txd", g, {31'd0, txd}, 32'd1);
          check("rst_mid_done", g, {31'd0, done}, 32'd0);
          check("rst_mid_busy", g, {31'd0, busy}, 32'd0);
          mode = 0; rst_hit = 1'b1;
          continue;
        end
        rst = 1'b0;

        // Stimulus for the next sampling edge.
`ifdef UART_TX_BREAK_EN
        brk = (c >= BRK_AT[g]) && (c < BRK_AT[g] + BRK_LN[g]);
`else
        brk = 1'b0;
`endif
        if (nfr < 3) begin
          valid = 1'b1;
          data  = (mode == 0) ? DB'(words[nfr]) : DB'($urandom);
        end else begin
          valid = ($urandom_range(0, 3) != 0);
          data  = DB'($urandom);
        end

        // Model advance to the next cycle.
        case (mode)
          0: begin
            if (brk) begin
              mode = 2;
            end else if (valid) begin
              fr = frame_bits(9'(data), DB, PAR);
              mode = 1; off = 0; nfr++;
            end
          end
          1: begin
            off++;
            if (off == LEN) mode = 0;
          end
          2: begin
            if (!brk) begin mode = 3; off = 0; end
          end
          default: begin
            off++;
            if (off == BPS) mode = 0;
          end
        endcase
      end
      // First three frames were offered back-to-back.
      check("n_frames", g, (starts.size() >= 3 && dones.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
      if (starts.size() >= 3 && dones.size() >= 3) begin
        check("frame_span", g, dones[0] - starts[0], LEN - 1);
        check("gap_1", g, starts[1] - dones[0], 32'd2);
        check("gap_2", g, starts[2] - dones[1], 32'd2);
      end
      check("reset_tested", g, {31'd0, rst_hit}, 32'd1);
      fin[g] = 1'b1;
    end
  end

  initial begin
    repeat (RUN_CYCLES + 50) @(posedge clk);
    check("all_finished", -1, {28'd0, fin}, {28'd0, {NI{1'b1}}});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
